// File: rtl/flex_fifo.sv
// flex_fifo: synchronous FIFO with runtime almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and a selectable read mode.
//
// Parameters
//   DATA_WIDTH  data path width in bits
//   DEPTH       capacity in words (power of two, >= 4)
//   FWFT        0 = standard registered read, 1 = first-word-fall-through
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous discard of all contents
//   wr_en, wr_data             write request and word
//   full, almost_full          no space / fill_level >= af_thresh
//   rd_en                      read request (standard) or pop (FWFT)
//   rd_data, rd_valid          registered read word and its valid flag
//   empty, almost_empty        nothing to read / fill_level <= ae_thresh
//   fill_level                 words held, including the FWFT output register
//   af_thresh, ae_thresh       runtime thresholds
//   overflow, underflow        sticky error flags
//   clr_err                    clears both sticky flags
module flex_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FWFT       = 0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [AW:0]           fill_level,
  input  logic [AW:0]           af_thresh,
  input  logic [AW:0]           ae_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned FW      = AW + 1;
  localparam bit          LP_FWFT = (FWFT != 0);

  // Storage and state
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [AW:0]           r_fill;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [AW:0]           w_mem_cnt;
  logic                  w_load;
  logic                  w_rd_valid_nxt;
  logic [AW:0]           w_fill_nxt;
  logic                  w_overflow_nxt;
  logic                  w_underflow_nxt;

  // Acceptance, prefetch and next-state decode
  always_comb begin
    w_full    = (r_fill == FW'(DEPTH));
    // In FWFT mode a word is only readable once it sits in the output register
    w_empty   = LP_FWFT ? !r_rd_valid : (r_fill == '0);
    w_wr_acc  = wr_en && !w_full && !flush;
    w_rd_acc  = rd_en && !w_empty && !flush;
    // Words still in the array (excludes the FWFT output register)
    w_mem_cnt = r_wr_ptr - r_rd_ptr;

    // FWFT refills the output register whenever it is free or being popped;
    // only words already in the array qualify, so a fresh write shows next edge
    if (LP_FWFT) begin
      w_load         = !flush && (w_mem_cnt != '0) && (!r_rd_valid || w_rd_acc);
      w_rd_valid_nxt = w_load || (r_rd_valid && !w_rd_acc);
    end else begin
      w_load         = w_rd_acc;
      w_rd_valid_nxt = w_rd_acc;
    end

    w_fill_nxt = r_fill;
    if (w_wr_acc && !w_rd_acc) begin
      w_fill_nxt = r_fill + FW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_fill_nxt = r_fill - FW'(1);
    end

    // A new error event wins over a coincident clear
    w_overflow_nxt  = (r_overflow  && !clr_err) || (wr_en && w_full  && !flush);
    w_underflow_nxt = (r_underflow && !clr_err) || (rd_en && w_empty && !flush);
  end

  // Memory array: no reset, written only on accepted writes
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, level, output register and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_fill     <= '0;
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_fill     <= w_fill_nxt;
        r_rd_valid <= w_rd_valid_nxt;
        if (w_wr_acc) begin
          r_wr_ptr <= r_wr_ptr + FW'(1);
        end
        if (w_load) begin
          r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
          r_rd_ptr  <= r_rd_ptr + FW'(1);
        end
      end
    end
  end

  // Output assignments; thresholds compare against the registered level
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_fill >= af_thresh);
  assign almost_empty = (r_fill <= ae_thresh);
  assign fill_level   = r_fill;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_flex_fifo.sv
// tb_flex_fifo: directed bench for flex_fifo with one standard-mode and one
// FWFT-mode instance (DATA_WIDTH=8, DEPTH=16) sharing clock, reset and thresholds.
module tb_flex_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DP = 16;
  localparam int unsigned AW = $clog2(DP);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr_err;
  logic [AW:0]   af_thresh;
  logic [AW:0]   ae_thresh;

  // Standard-mode instance signals
  logic          s_flush, s_wr_en, s_rd_en;
  logic [DW-1:0] s_wr_data, s_rd_data;
  logic          s_full, s_afull, s_rd_valid, s_empty, s_aempty, s_ovf, s_udf;
  logic [AW:0]   s_fill;

  // FWFT instance signals
  logic          f_flush, f_wr_en, f_rd_en;
  logic [DW-1:0] f_wr_data, f_rd_data;
  logic          f_full, f_afull, f_rd_valid, f_empty, f_aempty, f_ovf, f_udf;
  logic [AW:0]   f_fill;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flex_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .full(s_full), .almost_full(s_afull),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty),
    .almost_empty(s_aempty), .fill_level(s_fill),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
  );

  flex_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .flush(f_flush),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full), .almost_full(f_afull),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
    .almost_empty(f_aempty), .fill_level(f_fill),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr_err = 1'b0;
    af_thresh = 5'd12; ae_thresh = 5'd4;
    s_flush = 0; s_wr_en = 0; s_rd_en = 0; s_wr_data = '0;
    f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
    #2;
    chk("rst_empty", 32'(s_empty), 32'd1);
    chk("rst_full", 32'(s_full), 32'd0);
    chk("rst_fill", 32'(s_fill), 32'd0);
    chk("rst_rd_valid", 32'(s_rd_valid), 32'd0);
    chk("rst_rd_data", 32'(s_rd_data), 32'd0);
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    chk("rst_udf", 32'(s_udf), 32'd0);
    chk("rst_aempty", 32'(s_aempty), 32'd1);
    chk("rst_afull", 32'(s_afull), 32'd0);
    chk("rst_f_empty", 32'(f_empty), 32'd1);
    #10 rst_n = 1'b1;

    // ---------------- standard mode ----------------
    // Fill 0x01..0x10, checking level and thresholds at every level
    for (int i = 1; i <= 16; i++) begin
      s_wr_en = 1; s_wr_data = DW'(i);
      tick();
      chk("fill_level", 32'(s_fill), 32'(i));
      chk("aempty_lvl", 32'(s_aempty), (i <= 4) ? 32'd1 : 32'd0);
      chk("afull_lvl", 32'(s_afull), (i >= 12) ? 32'd1 : 32'd0);
    end
    chk("full_at16", 32'(s_full), 32'd1);
    s_wr_data = 8'hEE;
    tick();
    chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_fill", 32'(s_fill), 32'd16);
    s_wr_en = 0;

    // Drain: data in order, valid right after each read edge
    for (int i = 1; i <= 16; i++) begin
      s_rd_en = 1;
      tick();
      chk("rd_valid", 32'(s_rd_valid), 32'd1);
      chk("rd_data", 32'(s_rd_data), 32'(i));
      chk("rd_fill", 32'(s_fill), 32'(16 - i));
    end
    s_rd_en = 0;
    tick();
    chk("rd_valid_drop", 32'(s_rd_valid), 32'd0);
    chk("rd_data_hold", 32'(s_rd_data), 32'h10);
    chk("empty_after", 32'(s_empty), 32'd1);

    // Underflow and clear, including clear racing a new error
    s_rd_en = 1;
    tick();
    chk("udf_set", 32'(s_udf), 32'd1);
    chk("udf_no_valid", 32'(s_rd_valid), 32'd0);
    clr_err = 1;
    tick();
    chk("udf_clr_race", 32'(s_udf), 32'd1);
    chk("ovf_cleared", 32'(s_ovf), 32'd0);
    s_rd_en = 0;
    tick();
    chk("udf_cleared", 32'(s_udf), 32'd0);
    clr_err = 0;

    // Simultaneous write and read while empty
    s_wr_en = 1; s_rd_en = 1; s_wr_data = 8'h55;
    tick();
    chk("wr_rd_empty_fill", 32'(s_fill), 32'd1);
    chk("wr_rd_empty_udf", 32'(s_udf), 32'd1);
    chk("wr_rd_empty_valid", 32'(s_rd_valid), 32'd0);
    s_wr_en = 0; s_rd_en = 0; clr_err = 1;
    tick();
    clr_err = 0;
    chk("udf_clr2", 32'(s_udf), 32'd0);
    s_rd_en = 1;
    tick();
    chk("rd_55", 32'(s_rd_data), 32'h55);
    s_rd_en = 0;

    // Fill to 8 then 40 cycles of concurrent write/read across pointer wrap
    for (int k = 0; k < 8; k++) begin
      s_wr_en = 1; s_wr_data = DW'(8'h20 + k);
      tick();
    end
    chk("fill8", 32'(s_fill), 32'd8);
    for (int k = 0; k < 40; k++) begin
      s_wr_en = 1; s_rd_en = 1; s_wr_data = DW'(8'h28 + k);
      tick();
      chk("wrap_fill", 32'(s_fill), 32'd8);
      chk("wrap_valid", 32'(s_rd_valid), 32'd1);
      chk("wrap_data", 32'(s_rd_data), 32'(8'h20 + k));
    end
    s_rd_en = 0;
    for (int k = 0; k < 8; k++) begin
      s_wr_data = DW'(8'h50 + k);
      tick();
    end
    chk("full_again", 32'(s_full), 32'd1);
    chk("afull_again", 32'(s_afull), 32'd1);
    // Write while full is dropped even with a concurrent read
    s_rd_en = 1; s_wr_data = 8'h99;
    tick();
    chk("full_wr_rd_fill", 32'(s_fill), 32'd15);
    chk("full_wr_rd_ovf", 32'(s_ovf), 32'd1);
    chk("full_wr_rd_data", 32'(s_rd_data), 32'h48);
    s_wr_en = 0; s_rd_en = 0;

    // Flush alone, then flush overriding write and read at level 5
    s_flush = 1;
    tick();
    s_flush = 0;
    chk("flush_fill", 32'(s_fill), 32'd0);
    chk("flush_data", 32'(s_rd_data), 32'd0);
    for (int k = 0; k < 5; k++) begin
      s_wr_en = 1; s_wr_data = DW'(8'h61 + k);
      tick();
    end
    chk("fill5", 32'(s_fill), 32'd5);
    s_flush = 1; s_rd_en = 1; s_wr_data = 8'h66;
    tick();
    s_flush = 0; s_wr_en = 0; s_rd_en = 0;
    chk("flush_wr_rd_fill", 32'(s_fill), 32'd0);
    chk("flush_wr_rd_valid", 32'(s_rd_valid), 32'd0);
    chk("flush_wr_rd_empty", 32'(s_empty), 32'd1);
    chk("flush_ovf_keep", 32'(s_ovf), 32'd1);
    chk("flush_udf_keep", 32'(s_udf), 32'd0);
    s_wr_en = 1; s_wr_data = 8'h77;
    tick();
    s_wr_en = 0; s_rd_en = 1;
    tick();
    s_rd_en = 0;
    chk("post_flush_data", 32'(s_rd_data), 32'h77);

    // Asynchronous reset in the middle of a write burst
    for (int k = 0; k < 3; k++) begin
      s_wr_en = 1; s_wr_data = DW'(8'h81 + k);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fill", 32'(s_fill), 32'd0);
    chk("arst_empty", 32'(s_empty), 32'd1);
    chk("arst_full", 32'(s_full), 32'd0);
    chk("arst_data", 32'(s_rd_data), 32'd0);
    chk("arst_valid", 32'(s_rd_valid), 32'd0);
    chk("arst_ovf", 32'(s_ovf), 32'd0);
    chk("arst_udf", 32'(s_udf), 32'd0);
    s_wr_en = 0;
    tick();
    rst_n = 1'b1;
    s_wr_en = 1; s_wr_data = 8'h3C;
    tick();
    s_wr_en = 0;
    chk("post_rst_fill", 32'(s_fill), 32'd1);
    s_rd_en = 1;
    tick();
    s_rd_en = 0;
    chk("post_rst_data", 32'(s_rd_data), 32'h3C);

    // ---------------- FWFT mode ----------------
    f_wr_en = 1; f_wr_data = 8'hA5;
    tick();
    f_wr_en = 0;
    chk("fw_n_valid", 32'(f_rd_valid), 32'd0);
    chk("fw_n_fill", 32'(f_fill), 32'd1);
    tick();
    chk("fw_n1_valid", 32'(f_rd_valid), 32'd1);
    chk("fw_n1_data", 32'(f_rd_data), 32'hA5);
    chk("fw_n1_empty", 32'(f_empty), 32'd0);
    f_rd_en = 1;
    tick();
    f_rd_en = 0;
    chk("fw_pop_empty", 32'(f_empty), 32'd1);
    chk("fw_pop_fill", 32'(f_fill), 32'd0);
    f_rd_en = 1;
    tick();
    f_rd_en = 0;
    chk("fw_udf", 32'(f_udf), 32'd1);

    // Back-to-back pops with no bubble
    for (int k = 0; k < 3; k++) begin
      f_wr_en = 1; f_wr_data = DW'(8'h11 + k);
      tick();
    end
    f_wr_en = 0;
    chk("fw_b2b_fill", 32'(f_fill), 32'd3);
    chk("fw_b2b_head", 32'(f_rd_data), 32'h11);
    for (int k = 1; k < 3; k++) begin
      f_rd_en = 1;
      tick();
      chk("fw_b2b_valid", 32'(f_rd_valid), 32'd1);
      chk("fw_b2b_data", 32'(f_rd_data), 32'(8'h11 + k));
    end
    tick();
    f_rd_en = 0;
    chk("fw_b2b_end_empty", 32'(f_empty), 32'd1);
    chk("fw_b2b_end_fill", 32'(f_fill), 32'd0);

    // Full capacity includes the output register
    for (int k = 0; k < 16; k++) begin
      f_wr_en = 1; f_wr_data = DW'(8'hC0 + k);
      tick();
    end
    chk("fw_full", 32'(f_full), 32'd1);
    chk("fw_full_fill", 32'(f_fill), 32'd16);
    chk("fw_full_head", 32'(f_rd_data), 32'hC0);
    tick();
    f_wr_en = 0;
    chk("fw_ovf", 32'(f_ovf), 32'd1);
    for (int k = 1; k < 16; k++) begin
      f_rd_en = 1;
      tick();
      chk("fw_drain_data", 32'(f_rd_data), 32'(8'hC0 + k));
    end
    tick();
    f_rd_en = 0;
    chk("fw_drain_empty", 32'(f_empty), 32'd1);
    chk("fw_drain_fill", 32'(f_fill), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
